// File: rtl/fir_out_pkg.sv
// Shared widths, output limits and the round/saturate helper for the FIR output quantizer.
// Pure package: no logic, no latency.
package fir_out_pkg;

    localparam int DEF_IN_W  = 39;
    localparam int DEF_OUT_W = 16;
    localparam int DEF_SHIFT = 15;

    localparam logic signed [DEF_OUT_W-1:0] OUT_MAX = {1'b0, {(DEF_OUT_W-1){1'b1}}};
    localparam logic signed [DEF_OUT_W-1:0] OUT_MIN = {1'b1, {(DEF_OUT_W-1){1'b0}}};

    // Takes the already rounding-biased sum; returns the clamped sample and raises sat.
    function automatic logic signed [63:0] round_sat(
        input  logic signed [63:0] sum,
        input  int                 shift,
        input  int                 out_w,
        output logic               sat
    );
        logic signed [63:0] q;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        q   = sum >>> shift;
        hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (out_w - 1));
        sat = (q > hi) || (q < lo);
        if (q > hi) return hi;
        if (q < lo) return lo;
        return q;
    endfunction

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// First-word-fall-through FIFO: head visible one cycle after a write into an empty FIFO.
// Backpressure: push is accepted when not full or when a pop happens on the same edge.
module fir_out_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [W-1:0]           push_dat_i,
    input  logic                   pop_i,
    output logic [W-1:0]           dat_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [LW-1:0] lvl_q, lvl_d;
    logic [W-1:0]  hold_q;
    logic          push_ok, pop_ok;

    assign empty_o = (lvl_q == '0);
    assign full_o  = (lvl_q == LW'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign level_o = lvl_q;
    // hold_q keeps the last popped sample so the output never shows stale slots.
    assign dat_o   = empty_o ? hold_q : mem_q[rd_q];

    always_comb begin
        lvl_d = lvl_q;
        case ({push_ok, pop_ok})
            2'b10:   lvl_d = lvl_q + LW'(1);
            2'b01:   lvl_d = lvl_q - LW'(1);
            default: lvl_d = lvl_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
            lvl_q  <= '0;
            hold_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= push_dat_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_ok) begin
                hold_q <= mem_q[rd_q];
                rd_q   <= rd_q + AW'(1);
            end
            lvl_q <= lvl_d;
        end
    end

endmodule

// File: rtl/fir_out_quantizer.sv
// Rounds 39-bit FIR results to saturated 16-bit samples and buffers them; 2-cycle latency.
// Backpressure: FIFO absorbs up to DEPTH samples; a sample arriving on a full FIFO with no read is dropped.
module fir_out_quantizer
    import fir_out_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SHIFT = DEF_SHIFT,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       iVALID,
    input  logic [IN_W-1:0]            iDATA,
    input  logic                       iCLR,
    input  logic                       iREADY,
    output logic                       oVALID,
    output logic [OUT_W-1:0]           oDATA,
    output logic                       oSAT,
    output logic                       oOVF,
    output logic [CNT_W-1:0]           oDROP_CNT,
    output logic [lvl_w(DEPTH)-1:0]    oLEVEL
);
    localparam logic [IN_W:0] RND = (IN_W + 1)'(1) << (SHIFT - 1);

    logic                   s1_vld_q;
    logic signed [IN_W:0]   s1_sum_q, s1_sum_d;
    logic signed [63:0]     sum_ext;
    logic [OUT_W-1:0]       s2_smp;
    logic                   s2_sat;
    logic                   full, empty, pop, drop, sat_ev;
    logic                   sat_q, sat_d, ovf_q, ovf_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    // One extra bit keeps the rounding bias from wrapping the most positive input.
    assign s1_sum_d = $signed({iDATA[IN_W-1], iDATA} + RND);
    assign sum_ext  = 64'(s1_sum_q);

    always_comb begin
        s2_sat = 1'b0;
        s2_smp = OUT_W'(round_sat(sum_ext, SHIFT, OUT_W, s2_sat));
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_vld_q <= 1'b0;
            s1_sum_q <= '0;
        end else begin
            s1_vld_q <= iVALID;
            if (iVALID) s1_sum_q <= s1_sum_d;
        end
    end

    fir_out_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .push_i     (s1_vld_q),
        .push_dat_i (s2_smp),
        .pop_i      (pop),
        .dat_o      (oDATA),
        .full_o     (full),
        .empty_o    (empty),
        .level_o    (oLEVEL)
    );

    assign oVALID = !empty;
    assign pop    = oVALID && iREADY;
    assign drop   = s1_vld_q && full && !pop;
    // Saturation is flagged even when the sample is then dropped.
    assign sat_ev = s1_vld_q && s2_sat;

    always_comb begin
        sat_d = sat_ev ? 1'b1 : (iCLR ? 1'b0 : sat_q);
        ovf_d = drop   ? 1'b1 : (iCLR ? 1'b0 : ovf_q);
        cnt_d = cnt_q;
        if (drop) begin
            if (iCLR)             cnt_d = CNT_W'(1);
            else if (~&cnt_q)     cnt_d = cnt_q + CNT_W'(1);
        end else if (iCLR) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sat_q <= 1'b0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            sat_q <= sat_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end

    assign oSAT      = sat_q;
    assign oOVF      = ovf_q;
    assign oDROP_CNT = cnt_q;

endmodule

// File: tb/tb_fir_out_quantizer.sv
// Randomized and directed bench for fir_out_quantizer against an arithmetic reference model.
module tb_fir_out_quantizer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        iVALID = 1'b0;
    logic [38:0] iDATA = '0;
    logic        iCLR = 1'b0;
    logic        iREADY = 1'b0;
    logic        oVALID;
    logic [15:0] oDATA;
    logic        oSAT;
    logic        oOVF;
    logic [7:0]  oDROP_CNT;
    logic [2:0]  oLEVEL;

    int vecs = 0;
    int errs = 0;

    // Reference model state
    bit     m_pv = 0;
    longint m_pd = 0;
    int     mq[$];
    int     m_last = 0;
    bit     m_sat = 0, m_ovf = 0;
    int     m_cnt = 0;

    fir_out_quantizer dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .iVALID    (iVALID),
        .iDATA     (iDATA),
        .iCLR      (iCLR),
        .iREADY    (iREADY),
        .oVALID    (oVALID),
        .oDATA     (oDATA),
        .oSAT      (oSAT),
        .oOVF      (oOVF),
        .oDROP_CNT (oDROP_CNT),
        .oLEVEL    (oLEVEL)
    );

    always #5 CLK = ~CLK;

    function automatic int ref_q(input longint x, output bit s);
        real r;
        r = $floor((real'(x) + 16384.0) / 32768.0);
        s = 0;
        if (r > 32767.0) begin s = 1; return 32767; end
        if (r < -32768.0) begin s = 1; return -32768; end
        return int'(r);
    endfunction

    task automatic model_reset();
        m_pv = 0; m_pd = 0; mq.delete(); m_last = 0;
        m_sat = 0; m_ovf = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input bit v, input longint d, input bit r, input bit c);
        bit s, sev, dr;
        int y;
        if (RESET) begin model_reset(); return; end
        sev = 0; dr = 0;
        if (r && mq.size() > 0) m_last = mq.pop_front();
        if (m_pv) begin
            y = ref_q(m_pd, s);
            sev = s;
            if (mq.size() < 4) mq.push_back(y);
            else dr = 1;
        end
        m_sat = sev ? 1'b1 : (c ? 1'b0 : m_sat);
        m_ovf = dr  ? 1'b1 : (c ? 1'b0 : m_ovf);
        if (dr) m_cnt = c ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        else if (c) m_cnt = 0;
        m_pv = v; m_pd = d;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("valid", oVALID, (mq.size() != 0) ? 1 : 0);
        chk("data", $signed(oDATA), (mq.size() != 0) ? mq[0] : m_last);
        chk("level", oLEVEL, mq.size());
        chk("sat", oSAT, m_sat);
        chk("ovf", oOVF, m_ovf);
        chk("drop_cnt", oDROP_CNT, m_cnt);
    endtask

    // Entered and left at a falling edge.
    task automatic cycle(input bit v, input longint d, input bit r, input bit c);
        iVALID = v; iDATA = d[38:0]; iREADY = r; iCLR = c;
        @(posedge CLK);
        model_edge(v, d, r, c);
        @(negedge CLK);
        compare();
    endtask

    function automatic longint rnd_dat();
        logic [63:0] u;
        longint x;
        int m;
        u = {$urandom, $urandom};
        x = $signed(u) >>> 25;
        m = $urandom_range(0, 3);
        if (m == 1) x = x >>> 8;
        if (m == 2) x = longint'(int'($urandom_range(0, 200)) - 100) * 16384
                        + longint'(int'($urandom_range(0, 2)) - 1);
        if (m == 3) x = x >>> 18;
        return x;
    endfunction

    initial begin
        // Reset state
        cycle(0, 0, 0, 0);
        cycle(1, 64'd12345 << 15, 1, 0);
        chk("rst_valid", oVALID, 0);
        chk("rst_data", oDATA, 0);
        chk("rst_level", oLEVEL, 0);
        RESET = 1'b0;

        // Rounding, round-half-up
        cycle(1, 16384, 1, 0);
        chk("rnd_lat", oVALID, 0);
        cycle(1, 16383, 1, 0);
        chk("rnd_first_valid", oVALID, 1);
        chk("rnd0", $signed(oDATA), 1);
        cycle(1, -16384, 1, 0);
        chk("rnd1", $signed(oDATA), 0);
        cycle(1, -16385, 1, 0);
        chk("rnd2", $signed(oDATA), 0);
        cycle(1, 98304, 1, 0);
        chk("rnd3", $signed(oDATA), -1);
        cycle(0, 0, 1, 0);
        chk("rnd4", $signed(oDATA), 3);
        chk("rnd_nosat", oSAT, 0);
        cycle(0, 0, 1, 0);
        chk("rnd_drain", oVALID, 0);

        // Saturation and sticky clear
        cycle(1, 64'sd1 <<< 30, 1, 0);
        chk("sat_before", oSAT, 0);
        cycle(1, -(64'sd1 <<< 38), 1, 0);
        chk("sat_set", oSAT, 1);
        chk("sat_hi", $signed(oDATA), 32767);
        cycle(0, 0, 1, 0);
        chk("sat_lo", $signed(oDATA), -32768);
        cycle(0, 0, 1, 1);
        chk("sat_clr", oSAT, 0);

        // Full FIFO drops
        for (int k = 1; k <= 6; k++) cycle(1, longint'(k) << 15, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("full_level", oLEVEL, 4);
        chk("full_ovf", oOVF, 1);
        chk("full_cnt", oDROP_CNT, 2);
        chk("full_head", $signed(oDATA), 1);
        for (int k = 2; k <= 4; k++) begin
            cycle(0, 0, 1, 0);
            chk("full_drain", $signed(oDATA), k);
        end
        cycle(0, 0, 1, 0);
        chk("full_empty", oVALID, 0);

        // Simultaneous read and write while full
        for (int k = 7; k <= 10; k++) cycle(1, longint'(k) << 15, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 64'd11 << 15, 0, 0);
        chk("rw_pre_level", oLEVEL, 4);
        cycle(0, 0, 1, 0);
        chk("rw_level", oLEVEL, 4);
        chk("rw_cnt", oDROP_CNT, 2);
        chk("rw_head", $signed(oDATA), 8);
        for (int k = 0; k < 5; k++) cycle(0, 0, 1, 0);

        // Random stream under toggling back-pressure
        for (int i = 0; i < 400; i++)
            cycle(1, rnd_dat(), (i % 2) == 0, $urandom_range(0, 15) == 0);
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 1) == 1, rnd_dat(), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 31) == 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0);

        // Asynchronous reset mid-stream
        cycle(1, 64'd3 << 15, 0, 0);
        cycle(1, 64'd4 << 15, 0, 0);
        cycle(1, 64'd6 << 15, 0, 0);
        chk("mid_pre_level", oLEVEL, 2);
        RESET = 1'b1;
        #1;
        chk("mid_valid", oVALID, 0);
        chk("mid_data", oDATA, 0);
        chk("mid_level", oLEVEL, 0);
        chk("mid_sat", oSAT, 0);
        chk("mid_ovf", oOVF, 0);
        chk("mid_cnt", oDROP_CNT, 0);
        model_reset();
        @(negedge CLK);
        cycle(1, 64'd7 << 15, 1, 0);
        RESET = 1'b0;
        cycle(1, 64'd5 << 15, 1, 0);
        chk("post_lat", oVALID, 0);
        cycle(0, 0, 1, 0);
        chk("post_valid", oVALID, 1);
        chk("post_data", $signed(oDATA), 5);
        chk("post_level", oLEVEL, 1);
        cycle(0, 0, 1, 0);
        chk("post_empty", oVALID, 0);
        chk("post_hold", $signed(oDATA), 5);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
